systolic_collector: RTL and testbench
=====================================

SYSTOLIC_COLLECTOR -- requirements
Module: systolic_collector

Interface
REQ-001 Parameter DIM, default 8, number of lanes (array columns) drained.
REQ-002 Parameter UWIDTH, default 2, unary word width per lane per cycle.
REQ-003 Parameter WINDOW, default 8, cycles of unary data accumulated per lane per job.
REQ-004 Parameter ACC_WIDTH, default 5, binary result width per lane.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous and active-low.
REQ-007 start  input  1  one-cycle job request; honoured only in IDLE.
REQ-008 syst_arr_out  input  [DIM][UWIDTH]  per-lane unary words from the array, skewed one cycle per lane.
REQ-009 result  output  [DIM][ACC_WIDTH]  per-lane binary totals, valid while out_valid=1.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result when out_valid & out_ready.
REQ-012 busy  output  1  high in COLLECT or HOLD.
REQ-013 unary_err  output  1  sticky flag: a sampled word was not thermometer-coded.

Function
REQ-014 FSM states IDLE, COLLECT, HOLD; IDLE->COLLECT on start; COLLECT->HOLD when cnt = WINDOW+DIM-2; HOLD->IDLE on out_valid & out_ready.
REQ-015 On the IDLE->COLLECT transition, all lane accumulators, cnt and unary_err clear to 0.
REQ-016 cnt starts at 0 in the first COLLECT cycle and increments by 1 each COLLECT cycle.
REQ-017 Lane i samples syst_arr_out[i] only in COLLECT with i <= cnt <= i+WINDOW-1 (deskew window).
REQ-018 Sampled word contributes its popcount (0..UWIDTH) to lane i's accumulator.
REQ-019 Accumulator saturates at 2^ACC_WIDTH-1; no wrap-around.
REQ-020 A sampled word is legal iff of form 0..01..1 (thermometer, LSB-filled); any illegal sampled word sets unary_err; still counted by popcount.
REQ-021 out_valid asserts exactly WINDOW+DIM cycles after the cycle start was sampled (default: start+16); asserted only in HOLD.
REQ-022 result and out_valid hold stable in HOLD until handshake; out_ready ignored outside HOLD.
REQ-023 start ignored in COLLECT and HOLD, including the handshake cycle; a new job requires start in IDLE.
REQ-024 result is registered; no combinational path from syst_arr_out or out_ready to any output.

Reset
REQ-025 reset_n low, asynchronously: state=IDLE, cnt=0, accumulators=0, result=0, out_valid=0, busy=0, unary_err=0.
REQ-026 Reset asserted mid-COLLECT or mid-HOLD discards the job; no partial result is ever presented.

Structure
REQ-027 Shared package systolic_pkg holds DIM, UWIDTH defaults and the collector state enum typedef.
REQ-028 One sub-module unary_lane_acc (window compare, popcount, saturating add, thermometer check) instantiated DIM times via generate.
REQ-029 Top holds the FSM, cnt, and handshake logic only.

Verification
REQ-030 Every lane fed 2'b11 for its full window, out_ready=1 -> out_valid at start+16, each result=16, unary_err=0.
REQ-031 Lane i fed 2'b01 only in its window, 2'b11 outside it -> each result=8; proves deskew boundaries.
REQ-032 ACC_WIDTH=4, all 2'b11 -> each result saturates at 15, no wrap.
REQ-033 Lane 3 fed one 2'b10 inside its window -> unary_err=1 until next start; lane 3 total includes +1.
REQ-034 out_ready held 0 for 5 cycles in HOLD with start pulses -> result/out_valid stable, start ignored, IDLE after handshake.
REQ-035 reset_n pulsed low at cnt=6 -> all outputs 0 immediately; next start yields a clean result.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared defaults and state encoding for the systolic array result collector.
package systolic_pkg;

    localparam int unsigned DEF_DIM       = 8;
    localparam int unsigned DEF_UWIDTH    = 2;
    localparam int unsigned DEF_WINDOW    = 8;
    localparam int unsigned DEF_ACC_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } collector_state_e;

endpackage

// File: rtl/systolic_collector_if.sv
// Job request, unary lane data and result handshake between the array side and the collector.
interface systolic_collector_if #(
    parameter int unsigned DIM       = systolic_pkg::DEF_DIM,
    parameter int unsigned UWIDTH    = systolic_pkg::DEF_UWIDTH,
    parameter int unsigned ACC_WIDTH = systolic_pkg::DEF_ACC_WIDTH
) ();

    logic                            start;
    logic [DIM-1:0][UWIDTH-1:0]      syst_arr_out;
    logic [DIM-1:0][ACC_WIDTH-1:0]   result;
    logic                            out_valid;
    logic                            out_ready;
    logic                            busy;
    logic                            unary_err;

    modport master (
        output start,
        output syst_arr_out,
        output out_ready,
        input  result,
        input  out_valid,
        input  busy,
        input  unary_err
    );

    modport slave (
        input  start,
        input  syst_arr_out,
        input  out_ready,
        output result,
        output out_valid,
        output busy,
        output unary_err
    );

endinterface

// File: rtl/unary_lane_acc.sv
// One collector lane: deskew window gate, popcount, saturating accumulate, thermometer check.
module unary_lane_acc
    import systolic_pkg::*;
#(
    parameter int unsigned LANE      = 0,
    parameter int unsigned UWIDTH    = DEF_UWIDTH,
    parameter int unsigned WINDOW    = DEF_WINDOW,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_clear,
    input  logic                 i_collect,
    input  logic [CNT_W-1:0]     i_cnt,
    input  logic [UWIDTH-1:0]    i_word,
    output logic [ACC_WIDTH-1:0] o_acc,
    output logic                 o_err_c
);

    localparam int unsigned POP_W = $clog2(UWIDTH + 1);
    localparam int unsigned SUM_W = ACC_WIDTH + 1;
    // One extra bit so LANE+WINDOW-1 never wraps against the counter
    localparam logic [CNT_W:0]     WIN_LO  = (CNT_W + 1)'(LANE);
    localparam logic [CNT_W:0]     WIN_HI  = (CNT_W + 1)'(LANE + WINDOW - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {ACC_WIDTH{1'b1}};

    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_W:0]       w_cnt_ext;
    logic                 w_sample;
    logic [POP_W-1:0]     w_pop;
    logic [SUM_W-1:0]     w_sum;
    logic [UWIDTH-1:0]    w_word_inc;
    logic                 w_legal;

    assign w_cnt_ext = {1'b0, i_cnt};
    assign w_sample  = i_collect && (w_cnt_ext >= WIN_LO) && (w_cnt_ext <= WIN_HI);

    // Popcount of the incoming unary word
    always_comb begin
        w_pop = '0;
        for (int unsigned b = 0; b < UWIDTH; b++) begin
            w_pop = w_pop + POP_W'(i_word[b]);
        end
    end

    assign w_sum = {1'b0, r_acc} + SUM_W'(w_pop);

    // LSB-filled thermometer words have no set bit above a clear one: w & (w+1) == 0
    assign w_word_inc = i_word + UWIDTH'(1);
    assign w_legal    = ((i_word & w_word_inc) == '0);
    assign o_err_c    = w_sample && !w_legal;

    // Saturating accumulator, cleared at job start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (w_sample) begin
            r_acc <= w_sum[ACC_WIDTH] ? ACC_MAX : w_sum[ACC_WIDTH-1:0];
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/systolic_collector.sv
// Drains skewed unary columns of a systolic array into per-lane binary totals with a valid/ready result.
module systolic_collector
    import systolic_pkg::*;
#(
    parameter int unsigned DIM       = DEF_DIM,
    parameter int unsigned UWIDTH    = DEF_UWIDTH,
    parameter int unsigned WINDOW    = DEF_WINDOW,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    systolic_collector_if.slave   bus
);

    localparam int unsigned      CNT_W    = $clog2(WINDOW + DIM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW + DIM - 2);

    collector_state_e              r_state;
    collector_state_e              w_next_state;
    logic                          w_clear;
    logic                          w_collect;
    logic [CNT_W-1:0]              r_cnt;
    logic [DIM-1:0][ACC_WIDTH-1:0] w_acc;
    logic [DIM-1:0]                w_lane_err;
    logic [DIM-1:0][ACC_WIDTH-1:0] r_result;
    logic                          r_out_valid;
    logic                          r_busy;
    logic                          r_unary_err;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state = ST_COLLECT;
                    w_clear      = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (r_cnt == CNT_LAST) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_out_valid && bus.out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_collect = (r_state == ST_COLLECT);

    // Collection cycle counter, one step per COLLECT cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_clear) begin
            r_cnt <= '0;
        end else if (w_collect) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Per-lane accumulators
    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
        unary_lane_acc #(
            .LANE      (gi),
            .UWIDTH    (UWIDTH),
            .WINDOW    (WINDOW),
            .ACC_WIDTH (ACC_WIDTH),
            .CNT_W     (CNT_W)
        ) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_clear   (w_clear),
            .i_collect (w_collect),
            .i_cnt     (r_cnt),
            .i_word    (bus.syst_arr_out[gi]),
            .o_acc     (w_acc[gi]),
            .o_err_c   (w_lane_err[gi])
        );
    end

    // Result capture on the first HOLD cycle (last lane finishes on HOLD entry), dropped on handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (r_state == ST_HOLD) begin
            if (!r_out_valid) begin
                r_out_valid <= 1'b1;
                r_result    <= w_acc;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Busy tracks the state the FSM is entering
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
        end
    end

    // Sticky non-thermometer flag, cleared only when a new job starts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_unary_err <= 1'b0;
        end else if (w_clear) begin
            r_unary_err <= 1'b0;
        end else if (|w_lane_err) begin
            r_unary_err <= 1'b1;
        end
    end

    assign bus.result    = r_result;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.unary_err = r_unary_err;

endmodule

// File: tb/tb_systolic_collector.sv
// Scoreboard bench: two collectors (ACC_WIDTH 5 and 4) share stimulus; monitors pop expected results on handshake.
module tb_systolic_collector;

    localparam int DIM = 8;
    localparam int UW  = 2;
    localparam int WIN = 8;

    typedef struct packed {
        logic [DIM-1:0][4:0] res;
        logic                err;
    } exp5_t;

    typedef struct packed {
        logic [DIM-1:0][3:0] res;
        logic                err;
    } exp4_t;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  start;
    logic                  out_ready;
    logic [DIM-1:0][UW-1:0] data;

    int n_cmp = 0;
    int n_err = 0;

    exp5_t q5[$];
    exp4_t q4[$];

    always #5 clk = ~clk;

    systolic_collector_if #(.DIM(DIM), .UWIDTH(UW), .ACC_WIDTH(5)) bus5 ();
    systolic_collector_if #(.DIM(DIM), .UWIDTH(UW), .ACC_WIDTH(4)) bus4 ();

    assign bus5.start        = start;
    assign bus5.syst_arr_out = data;
    assign bus5.out_ready    = out_ready;
    assign bus4.start        = start;
    assign bus4.syst_arr_out = data;
    assign bus4.out_ready    = out_ready;

    systolic_collector #(.DIM(DIM), .UWIDTH(UW), .WINDOW(WIN), .ACC_WIDTH(5)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus5.slave)
    );

    systolic_collector #(.DIM(DIM), .UWIDTH(UW), .WINDOW(WIN), .ACC_WIDTH(4)) u_dut_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lane word driven at collect cycle k (k<0: idle filler, illegal but never sampled)
    function automatic logic [1:0] pat(input int mode, input int lane, input int k);
        logic in_win;
        in_win = (k >= lane) && (k <= lane + WIN - 1);
        if (k < 0) return 2'b10;
        case (mode)
            0:       return 2'b11;
            1:       return in_win ? 2'b01 : 2'b11;
            2:       return (lane == 3 && k == 5) ? 2'b10 : 2'b11;
            default: return in_win ? (((k - lane) < lane) ? 2'b11 : 2'b00) : 2'b10;
        endcase
    endfunction

    // Hand-computed totals: mode0 8x2=16, mode1 8x1=8, mode2 lane3 7x2+1=15, mode3 lane i gets i words of 2
    function automatic exp5_t make_exp5(input int mode);
        exp5_t e;
        for (int l = 0; l < DIM; l++) begin
            case (mode)
                0:       e.res[l] = 5'd16;
                1:       e.res[l] = 5'd8;
                2:       e.res[l] = (l == 3) ? 5'd15 : 5'd16;
                default: e.res[l] = 5'(2 * l);
            endcase
        end
        e.err = (mode == 2);
        return e;
    endfunction

    // Same totals with a 4-bit accumulator: anything above 15 sticks at 15
    function automatic exp4_t make_exp4(input int mode);
        exp4_t e;
        for (int l = 0; l < DIM; l++) begin
            case (mode)
                0:       e.res[l] = 4'd15;
                1:       e.res[l] = 4'd8;
                2:       e.res[l] = 4'd15;
                default: e.res[l] = 4'(2 * l);
            endcase
        end
        e.err = (mode == 2);
        return e;
    endfunction

    task automatic drive_data(input int mode, input int k);
        for (int l = 0; l < DIM; l++) begin
            data[l] = pat(mode, l, k);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid5"}, 64'(bus5.out_valid), 64'(0));
        check({tag, "_busy5"},  64'(bus5.busy),      64'(0));
        check({tag, "_err5"},   64'(bus5.unary_err), 64'(0));
        check({tag, "_res5"},   64'(bus5.result),    64'(0));
        check({tag, "_valid4"}, 64'(bus4.out_valid), 64'(0));
        check({tag, "_res4"},   64'(bus4.result),    64'(0));
    endtask

    // One job: start, 15 collect cycles, latency check, optional stalled HOLD, handshake
    task automatic run_job(input int mode, input int hold, input int abort_k);
        exp5_t e5;
        e5 = make_exp5(mode);
        if (abort_k < 0) begin
            q5.push_back(e5);
            q4.push_back(make_exp4(mode));
        end
        out_ready = (hold == 0);
        start = 1'b1;
        drive_data(mode, -1);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= WIN + DIM - 2; k++) begin
            if (k == abort_k) begin
                check("abort_err_before", 64'(bus5.unary_err), 64'(1));
                check("abort_busy_before", 64'(bus5.busy), 64'(1));
                reset_n = 1'b0;
                #1;
                check_all_zero("abort");
                @(negedge clk);
                reset_n = 1'b1;
                drive_data(0, -1);
                @(negedge clk);
                check_all_zero("post_abort");
                return;
            end
            if (k == 1) check("busy_collect", 64'(bus5.busy), 64'(1));
            drive_data(mode, k);
            @(negedge clk);
        end
        // 15 edges after start: still collecting the last lane's result
        check("valid_early", 64'(bus5.out_valid), 64'(0));
        drive_data(mode, -1);
        @(negedge clk);
        // 16 edges after start
        check("valid_at_16", 64'(bus5.out_valid), 64'(1));
        check("valid_at_16_sat", 64'(bus4.out_valid), 64'(1));
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                start = (h % 2 == 0);
                check("hold_valid", 64'(bus5.out_valid), 64'(1));
                check("hold_result", 64'(bus5.result), 64'(e5.res));
                @(negedge clk);
            end
            out_ready = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end else begin
            @(negedge clk);
        end
        check("idle_valid", 64'(bus5.out_valid), 64'(0));
        check("idle_busy", 64'(bus5.busy), 64'(0));
        @(negedge clk);
        check("idle_busy_later", 64'(bus5.busy), 64'(0));
    endtask

    // Scoreboard monitor for the 5-bit collector
    always @(negedge clk) begin
        exp5_t e;
        #2;
        if (reset_n && bus5.out_valid && bus5.out_ready) begin
            if (q5.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb5_unexpected: got result %0h with nothing expected", bus5.result);
            end else begin
                e = q5.pop_front();
                check("sb5_result", 64'(bus5.result), 64'(e.res));
                check("sb5_err", 64'(bus5.unary_err), 64'(e.err));
            end
        end
    end

    // Scoreboard monitor for the saturating 4-bit collector
    always @(negedge clk) begin
        exp4_t e;
        #2;
        if (reset_n && bus4.out_valid && bus4.out_ready) begin
            if (q4.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb4_unexpected: got result %0h with nothing expected", bus4.result);
            end else begin
                e = q4.pop_front();
                check("sb4_result", 64'(bus4.result), 64'(e.res));
                check("sb4_err", 64'(bus4.unary_err), 64'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        data      = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");

        run_job(0, 0, -1);
        run_job(1, 5, -1);
        run_job(2, 0, -1);
        check("err_sticky_idle", 64'(bus5.unary_err), 64'(1));
        run_job(3, 0, -1);
        run_job(2, 0, 7);
        run_job(0, 0, -1);

        repeat (4) @(negedge clk);
        check("q5_drained", 64'(q5.size()), 64'(0));
        check("q4_drained", 64'(q4.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
